// File: rtl/chacha_pkg.sv
// Shared types and constants for the ChaCha stream front-end.
package chacha_pkg;

    localparam int unsigned CHACHA_BLOCK_BITS = 512;
    localparam int unsigned WORD_BITS = 32;

    typedef enum logic [1:0] {
        StFill,
        StKick,
        StWait,
        StDrain
    } seq_state_t;

    function automatic int unsigned words_per_block(input int unsigned number_of_blocks);
        return (number_of_blocks * CHACHA_BLOCK_BITS) / WORD_BITS;
    endfunction

endpackage

// File: rtl/chacha_stream_sequencer.sv
// Packs a 32-bit word stream into one core block, kicks the ChaCha core, and
// unpacks the crypted block back onto a 32-bit output stream.
module chacha_stream_sequencer
    import chacha_pkg::*;
#(
    parameter int unsigned NUMBER_OF_BLOCKS = 1,
    parameter int unsigned BLOCK_SIZE_BITS = NUMBER_OF_BLOCKS * CHACHA_BLOCK_BITS
) (
    input  logic                       aclk,
    input  logic                       areset,
    input  logic                       core_enable,
    input  logic [31:0]                s_tdata,
    input  logic                       s_tvalid,
    output logic                       s_tready,
    input  logic                       s_tlast,
    output logic [31:0]                m_tdata,
    output logic                       m_tvalid,
    input  logic                       m_tready,
    output logic                       m_tlast,
    output logic [BLOCK_SIZE_BITS-1:0] core_data_in,
    output logic                       core_next_block,
    input  logic [BLOCK_SIZE_BITS-1:0] core_data_out,
    input  logic                       core_data_valid,
    output logic                       busy,
    output logic [31:0]                block_count
);

    localparam int unsigned WORDS = BLOCK_SIZE_BITS / WORD_BITS;
    localparam int unsigned CW = $clog2(WORDS) + 1;
    localparam int unsigned IW = (WORDS > 1) ? $clog2(WORDS) : 1;
    localparam logic [CW-1:0] WordsC = CW'(WORDS);

    seq_state_t                      state_q;
    logic [WORDS-1:0][WORD_BITS-1:0] in_buf_q;
    logic [WORDS-1:0][WORD_BITS-1:0] out_buf_q;
    logic [CW-1:0]                   wcnt_q;
    logic [CW-1:0]                   rcnt_q;
    logic [CW-1:0]                   nvalid_q;
    logic                            last_flag_q;
    logic                            blank_q;
    logic                            s_tready_q;
    logic                            m_tvalid_q;
    logic                            m_tlast_q;
    logic [31:0]                     m_tdata_q;
    logic                            next_block_q;
    logic                            busy_q;
    logic [31:0]                     block_count_q;

    logic [CW-1:0] wcnt_inc;
    logic [CW-1:0] rcnt_inc;
    logic [CW-1:0] nvalid_m1;

    assign wcnt_inc  = wcnt_q + 1'b1;
    assign rcnt_inc  = rcnt_q + 1'b1;
    assign nvalid_m1 = nvalid_q - 1'b1;

    always_ff @(posedge aclk) begin
        if (areset) begin
            state_q       <= StFill;
            in_buf_q      <= '0;
            out_buf_q     <= '0;
            wcnt_q        <= '0;
            rcnt_q        <= '0;
            nvalid_q      <= '0;
            last_flag_q   <= 1'b0;
            blank_q       <= 1'b0;
            s_tready_q    <= 1'b0;
            m_tvalid_q    <= 1'b0;
            m_tlast_q     <= 1'b0;
            m_tdata_q     <= '0;
            next_block_q  <= 1'b0;
            busy_q        <= 1'b0;
            block_count_q <= '0;
        end else begin
            case (state_q)
                StFill: begin
                    s_tready_q <= 1'b1;
                    if (s_tvalid && s_tready_q) begin
                        in_buf_q[wcnt_q[IW-1:0]] <= s_tdata;
                        wcnt_q <= wcnt_inc;
                        busy_q <= 1'b1;
                        // Unwritten words are already zero: the buffer is cleared after each drain.
                        if (wcnt_inc == WordsC || s_tlast) begin
                            nvalid_q     <= wcnt_inc;
                            last_flag_q  <= s_tlast;
                            s_tready_q   <= 1'b0;
                            next_block_q <= core_enable;
                            state_q      <= StKick;
                        end
                    end
                end
                StKick: begin
                    // next_block_q high means the strobe is on the wire this cycle.
                    if (next_block_q) begin
                        next_block_q <= 1'b0;
                        blank_q      <= 1'b1;
                        state_q      <= StWait;
                    end else begin
                        next_block_q <= core_enable;
                    end
                end
                StWait: begin
                    if (!core_enable) begin
                        state_q <= StKick;
                    end else if (blank_q) begin
                        blank_q <= 1'b0;
                    end else if (core_data_valid) begin
                        out_buf_q  <= core_data_out;
                        rcnt_q     <= '0;
                        m_tvalid_q <= 1'b1;
                        m_tdata_q  <= core_data_out[WORD_BITS-1:0];
                        m_tlast_q  <= last_flag_q && (nvalid_q == CW'(1));
                        state_q    <= StDrain;
                    end
                end
                StDrain: begin
                    if (m_tready) begin
                        if (rcnt_q == nvalid_m1) begin
                            m_tvalid_q    <= 1'b0;
                            m_tlast_q     <= 1'b0;
                            m_tdata_q     <= '0;
                            block_count_q <= block_count_q + 32'd1;
                            wcnt_q        <= '0;
                            in_buf_q      <= '0;
                            s_tready_q    <= 1'b1;
                            busy_q        <= 1'b0;
                            state_q       <= StFill;
                        end else begin
                            rcnt_q    <= rcnt_inc;
                            m_tdata_q <= out_buf_q[rcnt_inc[IW-1:0]];
                            m_tlast_q <= last_flag_q && (rcnt_inc == nvalid_m1);
                        end
                    end
                end
                default: state_q <= StFill;
            endcase
        end
    end

    assign s_tready        = s_tready_q;
    assign m_tvalid        = m_tvalid_q;
    assign m_tlast         = m_tlast_q;
    assign m_tdata         = m_tdata_q;
    assign core_data_in    = in_buf_q;
    assign core_next_block = next_block_q;
    assign busy            = busy_q;
    assign block_count     = block_count_q;

endmodule
